// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: per-stage prediction tracking record
// and default widths.
package branch_resolver_pkg;

    localparam int unsigned PCW_DEF  = 32;
    localparam int unsigned IDXW_DEF = 2;
    localparam int unsigned CNTW_DEF = 16;

    typedef struct packed {
        logic                valid;
        logic [PCW_DEF-1:0]  pc;
        logic                pred;
        logic [IDXW_DEF-1:0] idx;
    } bp_track_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch, MEM-resolve and predictor-update signals between the pipeline and the
// branch resolver.
interface branch_resolver_if #(
    parameter int unsigned PCW  = 32,
    parameter int unsigned IDXW = 2,
    parameter int unsigned CNTW = 16
);
    logic            if_valid;
    logic [PCW-1:0]  if_pc;
    logic            PRresult;
    logic [IDXW-1:0] ifprindex;
    logic            stall;
    logic            mm_isbranch;
    logic            mm_taken;
    logic [PCW-1:0]  mm_target;
    logic            ABtaken;
    logic [IDXW-1:0] mmprindex;
    logic            pr_update;
    logic            mispredict;
    logic [PCW-1:0]  recover_pc;
    logic [CNTW-1:0] branch_cnt;
    logic [CNTW-1:0] mispred_cnt;

    modport master (
        output if_valid, if_pc, PRresult, stall, mm_isbranch, mm_taken, mm_target,
        input  ifprindex, ABtaken, mmprindex, pr_update, mispredict, recover_pc,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_valid, if_pc, PRresult, stall, mm_isbranch, mm_taken, mm_target,
        output ifprindex, ABtaken, mmprindex, pr_update, mispredict, recover_pc,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolver_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    output logic [CNTW-1:0] cnt_o
);
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_resolver.sv
// Carries each fetch's prediction from IF to MEM, resolves it there, drives the
// predictor update and a one-cycle mispredict flush with recovery PC.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int unsigned PCW  = PCW_DEF,
    parameter int unsigned IDXW = IDXW_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input logic              CLK,
    input logic              nRST,
    branch_resolver_if.slave br
);
    bp_track_t if_rec;
    bp_track_t id_q, id_d, ex_q, ex_d, mm_q, mm_d;
    logic      done_q, done_d;
    logic      resolve, mispred;

    always_comb begin
        if_rec  = '{valid: br.if_valid, pc: br.if_pc, pred: br.PRresult,
                    idx: br.if_pc[IDXW+1:2]};
        resolve = mm_q.valid & br.mm_isbranch & ~done_q;
        mispred = resolve & (mm_q.pred != br.mm_taken);

        id_d   = id_q;
        ex_d   = ex_q;
        mm_d   = mm_q;
        done_d = done_q;
        if (!br.stall) begin
            id_d   = if_rec;
            ex_d   = id_q;
            mm_d   = ex_q;
            done_d = 1'b0;
        end else if (resolve) begin
            done_d = 1'b1;
        end

        // Flush kills the wrong-path IF/ID/EX contents, including the EX record
        // that would otherwise move into MEM on an unstalled edge.
        if (mispred) begin
            id_d.valid = 1'b0;
            ex_d.valid = 1'b0;
            if (!br.stall) mm_d.valid = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            id_q   <= '0;
            ex_q   <= '0;
            mm_q   <= '0;
            done_q <= 1'b0;
        end else begin
            id_q   <= id_d;
            ex_q   <= ex_d;
            mm_q   <= mm_d;
            done_q <= done_d;
        end
    end

    assign br.ifprindex  = br.if_pc[IDXW+1:2];
    assign br.ABtaken    = br.mm_taken;
    assign br.mmprindex  = mm_q.idx;
    assign br.pr_update  = resolve;
    assign br.mispredict = mispred;
    assign br.recover_pc = br.mm_taken ? br.mm_target : (mm_q.pc + PCW'(4));

    sat_counter #(.CNTW(CNTW)) u_branch_cnt (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .inc_i  (resolve),
        .cnt_o  (br.branch_cnt)
    );

    sat_counter #(.CNTW(CNTW)) u_mispred_cnt (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .inc_i  (mispred),
        .cnt_o  (br.mispred_cnt)
    );
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: in-flight instruction model plus
// hand-computed spot checks.
module tb_branch_resolver;
    localparam int unsigned PCW  = 32;
    localparam int unsigned IDXW = 2;
    localparam int unsigned CNTW = 4;
    localparam int          CMAX = (1 << CNTW) - 1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    branch_resolver_if #(.PCW(PCW), .IDXW(IDXW), .CNTW(CNTW)) br ();

    branch_resolver #(.PCW(PCW), .IDXW(IDXW), .CNTW(CNTW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .br   (br)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // In-flight instructions; age 1 = ID, 2 = EX, 3 = MEM.
    typedef struct {
        logic [31:0] pc;
        bit          pred;
        int          age;
        bit          resolved;
    } inst_t;

    inst_t q[$];
    int    bcnt  = 0;
    int    mcnt  = 0;
    bit    ready = 0;

    function automatic int mem_idx();
        for (int i = 0; i < q.size(); i++)
            if (q[i].age == 3) return i;
        return -1;
    endfunction

    always @(posedge CLK) begin : model
        int  m;
        bit  res, mis;
        if (!nRST) begin
            q.delete();
            bcnt  = 0;
            mcnt  = 0;
            ready = 1;
        end else if (ready) begin
            m   = mem_idx();
            res = (m >= 0) && br.mm_isbranch && !q[m].resolved;
            mis = res && (q[m].pred != br.mm_taken);
            if (res && bcnt < CMAX) bcnt++;
            if (mis && mcnt < CMAX) mcnt++;
            if (mis)
                for (int i = q.size() - 1; i >= 0; i--)
                    if (q[i].age < 3) q.delete(i);
            if (!br.stall) begin
                for (int i = q.size() - 1; i >= 0; i--)
                    if (q[i].age == 3) q.delete(i);
                foreach (q[i]) q[i].age++;
                if (br.if_valid && !mis)
                    q.push_back('{pc: br.if_pc, pred: br.PRresult, age: 1, resolved: 0});
            end else if (res) begin
                q[mem_idx()].resolved = 1;
            end
        end
    end

    always @(negedge CLK) begin : compare
        int          m;
        bit          res, mis;
        logic [31:0] exp_pc;
        if (ready) begin
            m   = mem_idx();
            res = (m >= 0) && br.mm_isbranch && !q[m].resolved;
            mis = res && (q[m].pred != br.mm_taken);
            chk("ifprindex", 64'(br.ifprindex), 64'((br.if_pc >> 2) % 4));
            chk("ABtaken", 64'(br.ABtaken), 64'(br.mm_taken));
            chk("pr_update", 64'(br.pr_update), 64'(res));
            chk("mispredict", 64'(br.mispredict), 64'(mis));
            chk("branch_cnt", 64'(br.branch_cnt), 64'(bcnt));
            chk("mispred_cnt", 64'(br.mispred_cnt), 64'(mcnt));
            if (m >= 0) chk("mmprindex", 64'(br.mmprindex), 64'((q[m].pc >> 2) % 4));
            if (mis) begin
                exp_pc = br.mm_taken ? br.mm_target : q[m].pc + 32'd4;
                chk("recover_pc", 64'(br.recover_pc), 64'(exp_pc));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic pred);
        br.if_valid = 1'b1;
        br.if_pc    = pc;
        br.PRresult = pred;
    endtask

    initial begin
        br.if_valid    = 1'b0;
        br.if_pc       = '0;
        br.PRresult    = 1'b0;
        br.stall       = 1'b0;
        br.mm_isbranch = 1'b0;
        br.mm_taken    = 1'b0;
        br.mm_target   = '0;
        nRST           = 1'b0;

        // 1: reset then idle
        tick(); tick();
        @(negedge CLK);
        chk("rst_pr_update", 64'(br.pr_update), 64'd0);
        chk("rst_mispredict", 64'(br.mispredict), 64'd0);
        chk("rst_recover_pc", 64'(br.recover_pc), 64'h4);
        chk("rst_branch_cnt", 64'(br.branch_cnt), 64'd0);
        chk("rst_mispred_cnt", 64'(br.mispred_cnt), 64'd0);

        // 2: correct taken prediction
        tick(); nRST = 1'b1; fetch(32'h40, 1'b1);
        tick(); br.if_valid = 1'b0;
        tick();
        tick(); br.mm_isbranch = 1'b1; br.mm_taken = 1'b1; br.mm_target = 32'h80;
        @(negedge CLK);
        chk("t2_pr_update", 64'(br.pr_update), 64'd1);
        chk("t2_mispredict", 64'(br.mispredict), 64'd0);
        chk("t2_mmprindex", 64'(br.mmprindex), 64'd0);
        tick(); br.mm_isbranch = 1'b0;
        @(negedge CLK);
        chk("t2_branch_cnt", 64'(br.branch_cnt), 64'd1);
        chk("t2_mispred_cnt", 64'(br.mispred_cnt), 64'd0);

        // 3: not-taken mispredict with younger branches behind it
        tick(); fetch(32'h4C, 1'b1);
        tick(); fetch(32'h50, 1'b0);
        tick(); fetch(32'h54, 1'b0);
        tick(); fetch(32'h58, 1'b0);
        br.mm_isbranch = 1'b1; br.mm_taken = 1'b0; br.mm_target = 32'h200;
        @(negedge CLK);
        chk("t3_mispredict", 64'(br.mispredict), 64'd1);
        chk("t3_recover_pc", 64'(br.recover_pc), 64'h50);
        chk("t3_mmprindex", 64'(br.mmprindex), 64'd3);
        tick(); br.if_valid = 1'b0; br.mm_taken = 1'b1;
        @(negedge CLK);
        chk("t3_younger_pr_update", 64'(br.pr_update), 64'd0);
        chk("t3_younger_mispredict", 64'(br.mispredict), 64'd0);
        tick(); tick(); tick(); br.mm_isbranch = 1'b0;
        @(negedge CLK);
        chk("t3_branch_cnt", 64'(br.branch_cnt), 64'd2);
        chk("t3_mispred_cnt", 64'(br.mispred_cnt), 64'd1);

        // 4: taken mispredict held by a 3-cycle stall
        tick(); fetch(32'h44, 1'b0);
        tick(); br.if_valid = 1'b0;
        tick();
        tick(); br.stall = 1'b1; br.mm_isbranch = 1'b1; br.mm_taken = 1'b1;
        br.mm_target = 32'h100;
        @(negedge CLK);
        chk("t4_pr_update_first", 64'(br.pr_update), 64'd1);
        chk("t4_mispredict_first", 64'(br.mispredict), 64'd1);
        chk("t4_recover_pc", 64'(br.recover_pc), 64'h100);
        chk("t4_mmprindex", 64'(br.mmprindex), 64'd1);
        tick();
        @(negedge CLK);
        chk("t4_pr_update_held", 64'(br.pr_update), 64'd0);
        chk("t4_mispredict_held", 64'(br.mispredict), 64'd0);
        chk("t4_mispred_cnt_once", 64'(br.mispred_cnt), 64'd2);
        tick();
        tick(); br.stall = 1'b0;
        @(negedge CLK);
        chk("t4_pr_update_release", 64'(br.pr_update), 64'd0);
        tick(); br.mm_isbranch = 1'b0;
        @(negedge CLK);
        chk("t4_branch_cnt", 64'(br.branch_cnt), 64'd3);
        chk("t4_mispred_cnt", 64'(br.mispred_cnt), 64'd2);

        // 5: saturation with 20 correctly predicted taken branches
        br.mm_isbranch = 1'b1; br.mm_taken = 1'b1; br.mm_target = 32'h3000;
        for (int i = 0; i < 20; i++) begin
            fetch(32'h1000 + 32'(4 * i), 1'b1);
            tick();
        end
        br.if_valid = 1'b0;
        tick(); tick(); tick();
        br.mm_isbranch = 1'b0;
        @(negedge CLK);
        chk("t5_branch_cnt_sat", 64'(br.branch_cnt), 64'hF);
        chk("t5_mispred_cnt", 64'(br.mispred_cnt), 64'd2);

        // 6: reset while a branch sits in EX
        tick(); fetch(32'h60, 1'b1);
        tick(); br.if_valid = 1'b0;
        tick(); nRST = 1'b0;
        tick(); nRST = 1'b1; br.mm_isbranch = 1'b1; br.mm_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t6_pr_update", 64'(br.pr_update), 64'd0);
            tick();
        end
        br.mm_isbranch = 1'b0;
        @(negedge CLK);
        chk("t6_branch_cnt", 64'(br.branch_cnt), 64'd0);
        chk("t6_mispred_cnt", 64'(br.mispred_cnt), 64'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Tracks every fetched instruction's branch prediction from IF down to MEM.
- At MEM it compares the actual branch outcome with the prediction made at fetch.
- Drives the predictor's update inputs (ABtaken, mmprindex, update strobe).
- Raises a one-cycle mispredict flush with the correct recovery PC, and keeps saturating branch/mispredict counters.

Parameters:
- PCW, 32, PC width in bits.
- IDXW, 2, predictor index width; index = pc[IDXW+1:2].
- CNTW, 16, performance counter width.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  synchronous active-low reset, sampled on posedge CLK.
- if_valid  input  1  IF holds a real instruction this cycle.
- if_pc  input  PCW  PC of the IF instruction.
- PRresult  input  1  predictor output for if_pc: 1 = predicted taken.
- ifprindex  output  IDXW  predictor lookup index = if_pc[IDXW+1:2] (combinational).
- stall  input  1  hold all tracking stages (hazard unit freeze).
- mm_isbranch  input  1  MEM instruction is BEQ/BNE (decoded from opfunc).
- mm_taken  input  1  actual branch condition at MEM.
- mm_target  input  PCW  resolved branch target at MEM.
- ABtaken  output  1  actual outcome sent to the predictor.
- mmprindex  output  IDXW  index of the MEM branch.
- pr_update  output  1  predictor must update this cycle.
- mispredict  output  1  flush IF/ID/EX and redirect fetch.
- recover_pc  output  PCW  fetch redirect PC, valid when mispredict=1.
- branch_cnt  output  CNTW  resolved branches, saturating.
- mispred_cnt  output  CNTW  mispredicts, saturating.

Behaviour:
- Tracking record per stage: {valid, pc, pred, idx}.
  - Stages: S_ID, S_EX, S_MM.
  - Each posedge with stall=0: S_ID <= IF record, S_EX <= S_ID, S_MM <= S_EX.
- stall=1: all three records hold; counters hold; outputs still evaluated from S_MM. A stalled MEM branch must produce pr_update only once.
  - Internal done flag is set after the first resolve cycle and cleared when S_MM advances.
- Resolve at MEM (combinational from S_MM and MEM inputs): resolve = S_MM.valid & mm_isbranch & ~done.
- ABtaken = mm_taken; mmprindex = S_MM.idx.
- pr_update = resolve.
- mispredict = resolve & (S_MM.pred != mm_taken).
- recover_pc:
  - mm_taken=1: mm_target.
  - mm_taken=0: S_MM.pc + 4, modulo 2^PCW (wrap at all-ones allowed).
- On mispredict, at the next edge:
  - S_ID and S_EX valid bits are cleared (flush), regardless of stall.
  - S_MM advances normally when stall=0.
  - The IF record is captured as invalid (the wrong-path fetch is killed).
- Counters:
  - branch_cnt += 1 on resolve.
  - mispred_cnt += 1 on mispredict.
  - Both saturate at all-ones: no wrap.
- Reset (nRST=0 at posedge): all valid bits, done, pred and idx = 0; pc fields = 0; counters = 0.
  - Hence pr_update=0, mispredict=0, recover_pc = 4 (0+4) after reset.
  - Reset mid-stall or mid-resolve overrides everything.
- Simultaneous stall and mispredict: the flush wins for S_ID/S_EX; S_MM holds with done=1 so there is no double update.
- Non-branch in MEM: pr_update=0 and mispredict=0, whatever the pred bit.
- Latency: IF to resolve is 3 unstalled edges; mispredict is combinational in the MEM cycle.

Decomposition:
- control_unit_types_pkg: add a bp_track_t packed struct {valid, pc, pred, idx}, plus IDXW/CNTW localparam defaults.
- One natural sub-module: sat_counter (CNTW wide, inc, sync active-low clear), instantiated twice.
- Stage registers stay in the top module.

Test Plan:
1. Reset then idle: nRST=0 for 2 cycles -> all outputs 0 except recover_pc=4; counters 0.
2. Correct prediction: fetch BEQ at pc=0x40, PRresult=1, mm_taken=1 three edges later -> pr_update=1, mmprindex=0, mispredict=0, branch_cnt=1, mispred_cnt=0.
3. Not-taken mispredict: pc=0x4C, PRresult=1, mm_taken=0 -> mispredict=1, recover_pc=0x50, mmprindex=3; next cycle S_ID/S_EX are invalid and a younger branch does not resolve.
4. Taken mispredict with stall: pc=0x44, PRresult=0, mm_taken=1, mm_target=0x100, stall=1 for 3 cycles -> pr_update and mispredict high in the first cycle only; mispred_cnt increments once.
5. Saturation: preload via 2^CNTW+3 resolved branches (or CNTW=4 override with 20 branches) -> branch_cnt stays 0xF.
6. Reset mid-flight: branch in S_EX, nRST=0 one cycle -> no pr_update follows; counters 0.
